// File: rtl/otter_pipe_pkg.sv
// -----------------------------------------------------------------------------
// otter_pipe_pkg
//   Shared definitions for the OTTER pipeline control blocks.
//   - RV32I major opcodes used by decode classification
//   - fwd_sel_t : operand source select for the decode-stage rs1/rs2 muxes
//   - sb_entry_t: one in-flight destination record of the hazard scoreboard
//   - helpers for picking the youngest matching stage and deciding stalls
// -----------------------------------------------------------------------------
package otter_pipe_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Encoding matches the FWD_A/FWD_B port values.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       alu_class;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0, alu_class: 1'b0};

    // hits[0] = EX, hits[1] = MEM, hits[2] = WB; the youngest stage wins.
    function automatic fwd_sel_t youngest(input logic [2:0] hits);
        if (hits[0]) return FWD_EX;
        if (hits[1]) return FWD_MEM;
        if (hits[2]) return FWD_WB;
        return FWD_RF;
    endfunction

    // A source stalls when its youngest producer is in EX or MEM and the
    // value is not yet available there (non-ALU result, or forwarding off).
    // A WB producer is always readable through rf_wr_out.
    function automatic logic src_stalls(input fwd_sel_t sel,
                                        input logic     ex_alu,
                                        input logic     mem_alu,
                                        input logic     fwd_en);
        case (sel)
            FWD_EX:  return !(ex_alu && fwd_en);
            FWD_MEM: return !(mem_alu && fwd_en);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// otter_hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side  (drives DEC_IR, BR_TAKEN; receives controls)
//   slave  : hazard control (receives DEC_IR, BR_TAKEN; drives controls)
//   Signals:
//     DEC_IR    instruction currently held in the decode IR register
//     BR_TAKEN  decode selected a non-sequential PC
//     PC_WRITE  PC register enable
//     DEC_EN    decode IR/PC and PC_WAIT register enable
//     DEC_CLEAR setnull for the decode IR register
//     EX_BUBBLE setnull for the execute IR register
//     FWD_A/B   rs1/rs2 source select (fwd_sel_t encoding)
//     STALL_CNT saturating stall-cycle count
//     FLUSH_CNT saturating flush count
// -----------------------------------------------------------------------------
interface otter_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      DEC_IR;
    logic             BR_TAKEN;
    logic             PC_WRITE;
    logic             DEC_EN;
    logic             DEC_CLEAR;
    logic             EX_BUBBLE;
    logic [1:0]       FWD_A;
    logic [1:0]       FWD_B;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output DEC_IR, BR_TAKEN,
        input  PC_WRITE, DEC_EN, DEC_CLEAR, EX_BUBBLE, FWD_A, FWD_B,
               STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  DEC_IR, BR_TAKEN,
        output PC_WRITE, DEC_EN, DEC_CLEAR, EX_BUBBLE, FWD_A, FWD_B,
               STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/otter_instr_class.sv
// -----------------------------------------------------------------------------
// otter_instr_class
//   Combinational register-usage classification of one RV32I instruction.
//   Ports:
//     ir        in  32  instruction word
//     writer    out  1  instruction writes rd
//     alu_class out  1  result produced by the ALU in EX (forwardable)
//     rd/rs1/rs2 out 5  register fields
//     use_rs1   out  1  instruction reads rs1
//     use_rs2   out  1  instruction reads rs2
//   Unknown opcodes (including the all-zero word left by setnull) neither
//   write nor read registers.
// -----------------------------------------------------------------------------
module otter_instr_class
    import otter_pipe_pkg::*;
(
    input  logic [31:0] ir,
    output logic        writer,
    output logic        alu_class,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use_rs1,
    output logic        use_rs2
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_funct7;

    assign opcode        = ir[6:0];
    assign funct3        = ir[14:12];
    assign rd            = ir[11:7];
    assign rs1           = ir[19:15];
    assign rs2           = ir[24:20];
    assign unused_funct7 = ^ir[31:25];

    always_comb begin
        writer    = 1'b0;
        alu_class = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OP: begin
                writer = 1'b1; alu_class = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM: begin
                writer = 1'b1; alu_class = 1'b1; use_rs1 = 1'b1;
            end
            LUI, AUIPC: begin
                writer = 1'b1; alu_class = 1'b1;
            end
            LOAD: begin
                writer = 1'b1; use_rs1 = 1'b1;
            end
            STORE, BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            JAL: begin
                writer = 1'b1;
            end
            JALR: begin
                writer = 1'b1; use_rs1 = 1'b1;
            end
            SYSTEM: begin
                // funct3 == 0 is ecall/ebreak/mret: no register result.
                writer  = (funct3 != 3'b000);
                use_rs1 = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: rtl/otter_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// otter_hazard_ctrl
//   Data/control hazard controller for the 5-stage OTTER pipeline.
//   A 3-entry scoreboard (EX, MEM, WB) tracks in-flight destinations; the
//   decode-stage sources are matched against it to produce a stall (with a
//   nop injected into EX) or a forwarding select. A taken branch squashes
//   the fetched instruction unless the pipe is stalled.
//   Parameters:
//     FWD_EN 1 = forward ALU results from EX/MEM, 0 = wait for WB
//     CNT_W  width of the saturating stall/flush counters
//   Ports:
//     CLK, RST  clock, asynchronous active-high reset
//     bus       otter_hazard_ctrl_if slave modport
// -----------------------------------------------------------------------------
module otter_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    otter_hazard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       dec_writer;
    logic       dec_alu_class;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_use_rs1;
    logic       dec_use_rs2;

    otter_instr_class u_class (
        .ir        (bus.DEC_IR),
        .writer    (dec_writer),
        .alu_class (dec_alu_class),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .use_rs1   (dec_use_rs1),
        .use_rs2   (dec_use_rs2)
    );

    // Index 0 = EX, 1 = MEM, 2 = WB.
    sb_entry_t        sb_reg [3];
    sb_entry_t        sb_ex_next;
    logic [2:0]       hit_a;
    logic [2:0]       hit_b;
    fwd_sel_t         sel_a;
    fwd_sel_t         sel_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // x0 is never a hazard even if some stage claims it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            assign hit_a[gi] = sb_reg[gi].valid && dec_use_rs1 &&
                               (dec_rs1 != 5'd0) && (sb_reg[gi].rd == dec_rs1);
            assign hit_b[gi] = sb_reg[gi].valid && dec_use_rs2 &&
                               (dec_rs2 != 5'd0) && (sb_reg[gi].rd == dec_rs2);
        end
    endgenerate

    assign sel_a = youngest(hit_a);
    assign sel_b = youngest(hit_b);

    assign stall = src_stalls(sel_a, sb_reg[0].alu_class, sb_reg[1].alu_class, FWD_EN) ||
                   src_stalls(sel_b, sb_reg[0].alu_class, sb_reg[1].alu_class, FWD_EN);

    // A stalled decode enters EX as a bubble, so it must not be recorded.
    always_comb begin
        sb_ex_next           = SB_EMPTY;
        sb_ex_next.valid     = !stall && dec_writer && (dec_rd != 5'd0);
        sb_ex_next.rd        = dec_rd;
        sb_ex_next.alu_class = dec_alu_class;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                sb_reg[i] <= SB_EMPTY;
            end
        end else begin
            sb_reg[0] <= sb_ex_next;
            sb_reg[1] <= sb_reg[0];
            sb_reg[2] <= sb_reg[1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (bus.DEC_CLEAR && (flush_cnt_reg != CNT_MAX)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Branch operands are stale while stalled, so BR_TAKEN is ignored then.
    assign bus.PC_WRITE  = !stall;
    assign bus.DEC_EN    = !stall;
    assign bus.EX_BUBBLE = stall;
    assign bus.DEC_CLEAR = bus.BR_TAKEN && !stall;
    assign bus.FWD_A     = stall ? FWD_RF : sel_a;
    assign bus.FWD_B     = stall ? FWD_RF : sel_b;
    assign bus.STALL_CNT = stall_cnt_reg;
    assign bus.FLUSH_CNT = flush_cnt_reg;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_hazard_ctrl
//   Two controllers (FWD_EN = 1 and FWD_EN = 0) driven one at a time. The
//   reference tracks, per architectural register, the cycle in which its most
//   recent writer left decode; the distance to the current cycle says where
//   that producer now sits (1 = EX, 2 = MEM, 3 = WB).
// -----------------------------------------------------------------------------
module tb_otter_hazard_ctrl;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] NOP         = 32'h00000013;
    localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
    localparam logic [31:0] LW_X3       = 32'h00002183;
    localparam logic [31:0] ADD_X4_X3   = 32'h00018233;
    localparam logic [31:0] ADDI_X5_1   = 32'h00100293;
    localparam logic [31:0] ADDI_X5_X5  = 32'h00228293;
    localparam logic [31:0] SUB_X6_X5   = 32'h40028333;
    localparam logic [31:0] ADDI_X0_7   = 32'h00700013;
    localparam logic [31:0] BEQ_X0_X0   = 32'h00000463;
    localparam logic [31:0] LW_X7       = 32'h00002383;
    localparam logic [31:0] BEQ_X7_X0   = 32'h00038463;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    otter_hazard_ctrl_if #(.CNT_W(CNT_W)) bus_f1 ();
    otter_hazard_ctrl_if #(.CNT_W(CNT_W)) bus_f0 ();

    otter_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(CNT_W)) dut_f1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_f1.slave)
    );

    otter_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(CNT_W)) dut_f0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_f0.slave)
    );

    logic        use_f1 = 1'b1;
    logic [31:0] ir     = 32'h0;
    logic        br     = 1'b0;

    assign bus_f1.DEC_IR   = use_f1 ? ir : 32'h0;
    assign bus_f1.BR_TAKEN = use_f1 ? br : 1'b0;
    assign bus_f0.DEC_IR   = use_f1 ? 32'h0 : ir;
    assign bus_f0.BR_TAKEN = use_f1 ? 1'b0 : br;

    logic             o_pcw, o_den, o_clr, o_bub;
    logic [1:0]       o_fa, o_fb;
    logic [CNT_W-1:0] o_sc, o_fc;

    assign o_pcw = use_f1 ? bus_f1.PC_WRITE  : bus_f0.PC_WRITE;
    assign o_den = use_f1 ? bus_f1.DEC_EN    : bus_f0.DEC_EN;
    assign o_clr = use_f1 ? bus_f1.DEC_CLEAR : bus_f0.DEC_CLEAR;
    assign o_bub = use_f1 ? bus_f1.EX_BUBBLE : bus_f0.EX_BUBBLE;
    assign o_fa  = use_f1 ? bus_f1.FWD_A     : bus_f0.FWD_A;
    assign o_fb  = use_f1 ? bus_f1.FWD_B     : bus_f0.FWD_B;
    assign o_sc  = use_f1 ? bus_f1.STALL_CNT : bus_f0.STALL_CNT;
    assign o_fc  = use_f1 ? bus_f1.FLUSH_CNT : bus_f0.FLUSH_CNT;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic wr;
        logic alu;
        logic u1;
        logic u2;
    } cls_t;

    function automatic cls_t classify(input logic [31:0] w);
        case (w[6:0])
            7'h33:        return 4'b1111;
            7'h13:        return 4'b1110;
            7'h37, 7'h17: return 4'b1100;
            7'h03:        return 4'b1010;
            7'h23, 7'h63: return 4'b0011;
            7'h6f:        return 4'b1000;
            7'h67:        return 4'b1010;
            7'h73:        return {(w[14:12] != 3'd0), 3'b010};
            default:      return 4'b0000;
        endcase
    endfunction

    int   cyc = 0;
    int   last_issue [32];
    logic last_alu   [32];
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;
    logic m_stall = 1'b0;

    function automatic int age_of(input int r, input logic used);
        int d;
        if (!used || r == 0) return 0;
        d = cyc - last_issue[r];
        return (d >= 1 && d <= 3) ? d : 0;
    endfunction

    always @(negedge CLK) begin
        cls_t c;
        int   ra, rb, rdn, aa, ab, ea, eb;
        logic sa, sb;
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                last_issue[i] = -100;
                last_alu[i]   = 1'b0;
            end
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end
        c   = classify(ir);
        ra  = int'(ir[19:15]);
        rb  = int'(ir[24:20]);
        rdn = int'(ir[11:7]);
        aa  = age_of(ra, c.u1);
        ab  = age_of(rb, c.u2);
        sa  = (aa == 1 || aa == 2) && (!last_alu[ra] || !use_f1);
        sb  = (ab == 1 || ab == 2) && (!last_alu[rb] || !use_f1);
        m_stall = sa || sb;
        ea = m_stall ? 0 : aa;
        eb = m_stall ? 0 : ab;

        check("pc_write",  int'(o_pcw), int'(!m_stall));
        check("dec_en",    int'(o_den), int'(!m_stall));
        check("ex_bubble", int'(o_bub), int'(m_stall));
        check("dec_clear", int'(o_clr), int'(br && !m_stall));
        check("fwd_a",     int'(o_fa),  ea);
        check("fwd_b",     int'(o_fb),  eb);
        check("stall_cnt", int'(o_sc),  m_stall_cnt);
        check("flush_cnt", int'(o_fc),  m_flush_cnt);

        if (!RST) begin
            if (m_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (br && !m_stall && m_flush_cnt < CNT_MAX) m_flush_cnt++;
            if (!m_stall && c.wr && rdn != 0) begin
                last_issue[rdn] = cyc;
                last_alu[rdn]   = c.alu;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    // Holds w in decode until the reference says it leaves; reports the
    // number of stall cycles and the outputs seen in the issuing cycle.
    task automatic issue(input logic [31:0] w, input logic b, output int nstall,
                         output int fa, output int fb, output int clr);
        ir = w;
        br = b;
        nstall = 0;
        fa = -1; fb = -1; clr = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK); #1;
            if (!m_stall) begin
                fa  = int'(o_fa);
                fb  = int'(o_fb);
                clr = int'(o_clr);
                @(posedge CLK); #1;
                $display("issue ir=%08h br=%0d stalls=%0d fwd_a=%0d fwd_b=%0d clear=%0d",
                         w, b, nstall, fa, fb, clr);
                return;
            end
            nstall++;
            @(posedge CLK); #1;
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout ir=%08h actual=stuck expected=issue", w);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic drain();
        int n, a, b, c;
        for (int i = 0; i < 3; i++) issue(NOP, 1'b0, n, a, b, c);
    endtask

    initial begin
        int ns, fa, fb, clr;

        // Reset state: empty scoreboard, BR_TAKEN passes through.
        ir = 32'h0;
        br = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK); #1;
        check("rst_pc_write",  int'(o_pcw), 1);
        check("rst_ex_bubble", int'(o_bub), 0);
        check("rst_fwd_a",     int'(o_fa),  0);
        check("rst_dec_clear", int'(o_clr), 1);
        check("rst_stall_cnt", int'(o_sc),  0);
        br = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        // EX forwarding
        issue(ADDI_X1_5, 1'b0, ns, fa, fb, clr);
        issue(ADD_X2_X1, 1'b0, ns, fa, fb, clr);
        check("ex_fwd_stalls", ns, 0);
        check("ex_fwd_a", fa, 1);
        check("ex_fwd_b", fb, 1);
        check("ex_fwd_stall_cnt", int'(o_sc), 0);
        drain();

        // Load-use
        issue(LW_X3, 1'b0, ns, fa, fb, clr);
        issue(ADD_X4_X3, 1'b0, ns, fa, fb, clr);
        check("load_use_stalls", ns, 2);
        check("load_use_fwd_a", fa, 3);
        check("load_use_fwd_b", fb, 0);
        check("load_use_stall_cnt", int'(o_sc), 2);
        drain();

        // Youngest match wins
        issue(ADDI_X5_1, 1'b0, ns, fa, fb, clr);
        issue(ADDI_X5_X5, 1'b0, ns, fa, fb, clr);
        issue(SUB_X6_X5, 1'b0, ns, fa, fb, clr);
        check("youngest_stalls", ns, 0);
        check("youngest_fwd_a", fa, 1);
        drain();

        // x0 never matches; taken branch flushes
        issue(ADDI_X0_7, 1'b0, ns, fa, fb, clr);
        issue(BEQ_X0_X0, 1'b1, ns, fa, fb, clr);
        check("x0_fwd_a", fa, 0);
        check("x0_fwd_b", fb, 0);
        check("flush_clear", clr, 1);
        issue(32'h0, 1'b0, ns, fa, fb, clr);
        check("flush_one_cycle", clr, 0);
        check("flush_cnt_1", int'(o_fc), 1);
        drain();

        // Stall beats flush
        issue(LW_X7, 1'b0, ns, fa, fb, clr);
        issue(BEQ_X7_X0, 1'b1, ns, fa, fb, clr);
        check("stall_flush_stalls", ns, 2);
        check("stall_flush_clear", clr, 1);
        check("stall_flush_fwd_a", fa, 3);
        issue(32'h0, 1'b0, ns, fa, fb, clr);
        drain();

        // Counter saturation
        for (int i = 0; i < 9; i++) issue(32'h0, 1'b1, ns, fa, fb, clr);
        issue(NOP, 1'b0, ns, fa, fb, clr);
        check("flush_cnt_sat", int'(o_fc), CNT_MAX);
        for (int i = 0; i < 4; i++) begin
            issue(LW_X3, 1'b0, ns, fa, fb, clr);
            issue(ADD_X4_X3, 1'b0, ns, fa, fb, clr);
        end
        check("stall_cnt_sat", int'(o_sc), CNT_MAX);
        drain();

        // Reset asserted in the middle of a load-use stall
        issue(LW_X3, 1'b0, ns, fa, fb, clr);
        ir = ADD_X4_X3;
        br = 1'b0;
        @(negedge CLK); #1;
        check("pre_rst_pc_write", int'(o_pcw), 0);
        RST = 1'b1;
        #1;
        check("mid_rst_pc_write",  int'(o_pcw), 1);
        check("mid_rst_ex_bubble", int'(o_bub), 0);
        check("mid_rst_stall_cnt", int'(o_sc),  0);
        check("mid_rst_flush_cnt", int'(o_fc),  0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        issue(ADD_X4_X3, 1'b0, ns, fa, fb, clr);
        check("post_rst_stalls", ns, 0);
        check("post_rst_fwd_a", fa, 0);
        drain();

        // Forwarding disabled
        RST = 1'b1;
        use_f1 = 1'b0;
        do_reset();
        issue(ADDI_X1_5, 1'b0, ns, fa, fb, clr);
        issue(ADD_X2_X1, 1'b0, ns, fa, fb, clr);
        check("nofwd_ex_stalls", ns, 2);
        check("nofwd_ex_fwd_a", fa, 3);
        check("nofwd_ex_fwd_b", fb, 3);
        check("nofwd_stall_cnt", int'(o_sc), 2);
        drain();
        issue(ADDI_X1_5, 1'b0, ns, fa, fb, clr);
        issue(NOP, 1'b0, ns, fa, fb, clr);
        issue(ADD_X2_X1, 1'b0, ns, fa, fb, clr);
        check("nofwd_mem_stalls", ns, 1);
        check("nofwd_mem_fwd_a", fa, 3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage OTTER (fetch, decode, execute, memory, writeback).
- Tracks in-flight destination registers in a 3-entry scoreboard covering EX, MEM and WB.
- Generates stall, bubble and flush controls plus operand-forwarding selects for the decode-stage rs1/rs2 values. These forwarded values feed the ALU source muxes, CondGen and TarGen.
- Replaces the ad-hoc data-resolution logic, and adds saturating stall and flush counters.

Parameters:
- FWD_EN, 1, 1 = forward ALU-class results from EX/MEM; 0 = stall on every RAW until the producer reaches WB.
- CNT_W, 16, width of the STALL_CNT and FLUSH_CNT counters.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- DEC_IR  in  32  instruction in the decode IR register
- BR_TAKEN  in  1  decode decoder selected a non-sequential PC (jal, jalr, taken branch)
- PC_WRITE  out  1  PC register enable
- DEC_EN  out  1  enable for the decode IR/PC registers and the PC_WAIT register
- DEC_CLEAR  out  1  setnull for the decode IR register (squash fetched instruction)
- EX_BUBBLE  out  1  setnull for the execute IR register (inject nop)
- FWD_A  out  2  rs1 source: 0 = RF, 1 = alu_out (EX), 2 = alu_reg_out (MEM), 3 = rf_wr_out (WB)
- FWD_B  out  2  rs2 source, same encoding as FWD_A
- STALL_CNT  out  CNT_W  saturating count of stall cycles
- FLUSH_CNT  out  CNT_W  saturating count of flushes

Behaviour:
- Decode classification (combinational)
  - rd = DEC_IR[11:7]. The instruction is a writer if its opcode is OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR, or SYSTEM with funct3 != 0.
  - alu_class = OP, OP-IMM, LUI or AUIPC.
  - Uses rs1: every opcode except LUI, AUIPC, JAL. Uses rs2: OP, STORE, BRANCH.
  - Unknown opcodes, including the 0x00000000 that setnull leaves behind, are non-writers and non-users.
- Scoreboard
  - Three entries {valid, rd, alu_class}: sb_ex, sb_mem, sb_wb.
  - Every edge: sb_wb <= sb_mem; sb_mem <= sb_ex; sb_ex <= stall ? invalid : decode info.
  - valid = writer && rd != 0.
- Match
  - Stage s matches rsN if sb_s.valid, sb_s.rd == rsN, and rsN is used.
  - x0 never matches.
  - When several stages match, the youngest wins: EX > MEM > WB.
- Stall (combinational)
  - Asserted if any used rsN has its youngest match in EX or MEM with (!alu_class || !FWD_EN).
  - A WB match never stalls; it forwards with sel = 3.
  - During a stall: PC_WRITE = 0, DEC_EN = 0, EX_BUBBLE = 1, FWD = 0.
- Forward
  - When not stalled: FWD_x = 1/2/3 for the youngest EX/MEM/WB match, else 0.
- Flush
  - DEC_CLEAR = BR_TAKEN && !stall.
  - BR_TAKEN is ignored while stalled, because the branch operands are not yet valid.
  - A flush does not stall: PC_WRITE = 1, DEC_EN = 1.
- Latency
  - A non-ALU producer (load, jal, jalr, csr) followed immediately by a consumer costs 2 stall cycles.
  - With a 1-instruction gap it costs 1 stall cycle. With a 2-instruction gap it costs 0 (WB forward).
- Counters
  - STALL_CNT += 1 per stalled cycle; FLUSH_CNT += 1 per DEC_CLEAR cycle.
  - Both saturate at all-ones.
- Reset
  - Asynchronous. Immediately clears all scoreboard entries and both counters.
  - While RST is high, outputs follow from the empty scoreboard: PC_WRITE = 1, DEC_EN = 1, EX_BUBBLE = 0, FWD_A = FWD_B = 0, DEC_CLEAR = BR_TAKEN.
  - Reset asserted mid-stall drops the stall in the same cycle.

Decomposition:
- Package otter_pipe_pkg:
  - opcode localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, SYSTEM)
  - fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}
  - sb_entry_t struct {valid, rd[4:0], alu_class}
- Sub-module otter_instr_class: combinational DEC_IR -> {writer, alu_class, rd, rs1, rs2, use_rs1, use_rs2}. It is reused by later pipeline blocks.

Test Plan:
- Forwarding from EX: addi x1,x0,5 then add x2,x1,x1 -> in the add's decode cycle FWD_A = FWD_B = 1, PC_WRITE = 1, STALL_CNT = 0.
- Load-use: lw x3,0(x0) then add x4,x3,x0 -> 2 cycles with PC_WRITE = 0 and EX_BUBBLE = 1, then FWD_A = 3, FWD_B = 0; STALL_CNT = 2.
- Youngest-match priority: addi x5,x0,1; addi x5,x5,2; sub x6,x5,x0 -> in the sub's decode cycle FWD_A = 1 (not 2), no stall.
- x0 and flush: addi x0,x0,7; beq x0,x0,+8 with BR_TAKEN = 1 -> FWD_A = FWD_B = 0, DEC_CLEAR = 1 for one cycle, FLUSH_CNT = 1.
- Stall over flush: lw x7,0(x0); beq x7,x0,+8 with BR_TAKEN = 1 -> DEC_CLEAR = 0 for 2 stall cycles, then DEC_CLEAR = 1 with FWD_A = 3.
- Reset mid-stall and FWD_EN = 0: assert RST during a load-use stall -> PC_WRITE = 1 and counters 0 before the next edge. With FWD_EN = 0, addi x1 then add x1 -> 2 stall cycles, then FWD_A = 3.
